fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the decoder. It owns the architectural PC register and issues single-word reads on a req/ack instruction-memory port. It presents each fetched word with its PC to the decoder through a valid/ready handshake. It accepts branch redirects from the PC-update logic and stops fetching permanently when the decoder reports halt.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (low 2 bits must be 0)
TIMEOUT_CYCLES, 255, max mem wait cycles before fault (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
mem_req  out  1  instruction read request
mem_addr  out  32  word address (byte address, bits[1:0]=0)
mem_ack  in  1  read data valid this cycle
mem_rdata  in  32  instruction word, valid when mem_ack=1
instr_valid  out  1  instr/instr_pc valid to decoder
dec_ready  in  1  decoder accepts instr this cycle
instr  out  32  fetched instruction
instr_pc  out  32  PC of instr
redirect_en  in  1  taken branch, load redirect_pc
redirect_pc  in  32  branch target (pc_nxt from PC logic)
halt  in  1  decoder flags current instr as halt
halted  out  1  fetch stopped
fetch_err  out  1  sticky memory-timeout fault (0 when feature off)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_err=0, squash=0. Reset mid-transaction abandons the request; memory must tolerate req dropping.
- States: FETCH, HOLD, HALT.
- FETCH:
  - mem_req=1 from the first cycle after reset exit; mem_addr=pc.
  - mem_req and mem_addr stay stable until mem_ack is sampled high. An ack in the first req cycle is legal.
  - On ack with squash=0: instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, mem_req<=0, go HOLD.
  - Minimum latency is 2 cycles from req to instr_valid.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until the handshake.
  - On dec_ready=1 with halt=0: pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC→0), instr_valid<=0, go FETCH.
  - On dec_ready=1 with halt=1: instr_valid<=0, halted<=1, go HALT.
- Redirect:
  - redirect_en in HOLD: pc<=redirect_pc & ~3, instr_valid<=0, go FETCH. Redirect has priority over dec_ready/halt in the same cycle; the held word is dropped.
  - redirect_en in FETCH before ack: pc_pending<=redirect_pc & ~3, squash<=1. The current request still runs to ack.
  - Ack with squash=1: data discarded, pc<=pc_pending, squash<=0, stay FETCH. A new request starts the next cycle (mem_req deasserted one cycle).
  - redirect_en in the same cycle as ack: treated as squash.
  - A second redirect before ack overwrites pc_pending.
- HALT: mem_req=0, instr_valid=0, halted=1. Ignores all inputs; only rst exits.
- No combinational path from mem_ack/mem_rdata to the decoder outputs; all outputs are registered.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on each new request and increments each FETCH cycle with mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT_CYCLES: fetch_err<=1 (sticky), halted<=1, go HALT, mem_req dropped.
  - An ack in the same cycle as the limit wins; no fault.
- Undefined: no counter logic; fetch_err tied to 0; a fetch waits forever.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum (FETCH/HOLD/HALT)
  - INSTR_W=32, PC_W=32, PC_STEP=4
  - PC_ALIGN_MASK=32'hFFFF_FFFC
- One natural sub-module: fetch_wdog, the timeout counter, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset with RESET_PC=0x100; mem acks 1 cycle after req; dec_ready=1 always → addresses 0x100, 0x104, 0x108; each instr_pc matches; 2-cycle spacing between instr_valid pulses.
- Stall: hold dec_ready=0 for 5 cycles in HOLD → instr/instr_pc stable, mem_req=0; release → pc advances by exactly 4.
- Redirect to 0x203 while FETCH at 0x40 awaits ack (ack 3 cycles later, data 0xDEAD_BEEF) → 0xDEAD_BEEF never presented; next mem_addr=0x200.
- Simultaneous redirect_en (target 0x80) and dec_ready=1 in HOLD at 0x10 → held word dropped, next fetch 0x80, not 0x14.
- dec_ready=1 with halt=1 at pc 0x20 → halted=1 next cycle, mem_req stays 0 for 20 cycles with redirect_en pulsed; rst → fetch resumes at RESET_PC.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_ack never asserted → fetch_err=1 and halted=1 after 8 wait cycles. Repeat with ack exactly at cycle 8 → no fault.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: state encoding, datapath widths, PC helpers.
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   localparam logic [PC_W-1:0] PC_STEP       = 32'd4;
   localparam logic [PC_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   // Force a byte address onto a word boundary.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return addr & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_wdog.sv
// Memory-wait watchdog for the fetch stage. Counts consecutive unacknowledged
// request cycles and flags expiry on the TIMEOUT_CYCLES-th one. An ack in that
// same cycle suppresses expiry.
module fetch_wdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic ack,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count;

   // Wait counter: held at zero between requests, advances on every unacked request cycle.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst || !req) begin
         count <= '0;
      end else if (!ack) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = req && !ack && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word reads on a req/ack
// port, hands each word to the decoder over valid/ready, follows branch
// redirects and stops for good on a decoder halt.
// Optional: define FETCH_TIMEOUT_EN to add a memory-wait watchdog that raises
// a sticky fetch_err and halts after TIMEOUT_CYCLES unacked cycles.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC       = 32'h0000_0000,
   parameter int              TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               instr_valid,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   input  logic               redirect_en,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt,
   output logic               halted,
   output logic               fetch_err
);

   fetch_state_e    state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_pending;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] redirect_tgt;
   logic            squash;
   logic            timeout_hit;

   assign pc_inc       = pc + PC_STEP;
   assign redirect_tgt = align_pc(redirect_pc);

`ifdef FETCH_TIMEOUT_EN
   fetch_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .req     (mem_req),
      .ack     (mem_ack),
      .expired (timeout_hit)
   );

   // Sticky fault flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_err <= 1'b0;
      end else if (timeout_hit) begin
         fetch_err <= 1'b1;
      end
   end
`else
   logic [31:0] timeout_unused;
   assign timeout_unused = TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
   assign fetch_err      = 1'b0;
`endif

   // Fetch sequencer: PC, memory request, decoder slot and halt state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         pc_pending  <= RESET_PC;
         squash      <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= RESET_PC;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         halted      <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (timeout_hit) begin
                  mem_req <= 1'b0;
                  squash  <= 1'b0;
                  halted  <= 1'b1;
                  state   <= HALT;
               end else if (!mem_req) begin
                  // Idle slot after reset or a squashed word: launch the next read,
                  // taking a redirect that lands in this very cycle.
                  mem_req <= 1'b1;
                  if (redirect_en) begin
                     pc       <= redirect_tgt;
                     mem_addr <= redirect_tgt;
                  end else begin
                     mem_addr <= pc;
                  end
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (redirect_en) begin
                     // Word arrives together with a redirect: it is stale, drop it.
                     pc     <= redirect_tgt;
                     squash <= 1'b0;
                  end else if (squash) begin
                     pc     <= pc_pending;
                     squash <= 1'b0;
                  end else begin
                     instr       <= mem_rdata;
                     instr_pc    <= pc;
                     instr_valid <= 1'b1;
                     state       <= HOLD;
                  end
               end else if (redirect_en) begin
                  // The outstanding read must still complete; remember where to go next.
                  pc_pending <= redirect_tgt;
                  squash     <= 1'b1;
               end
            end

            HOLD: begin
               if (redirect_en) begin
                  pc          <= redirect_tgt;
                  instr_valid <= 1'b0;
                  mem_req     <= 1'b1;
                  mem_addr    <= redirect_tgt;
                  state       <= FETCH;
               end else if (dec_ready) begin
                  instr_valid <= 1'b0;
                  if (halt) begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end else begin
                     pc       <= pc_inc;
                     mem_req  <= 1'b1;
                     mem_addr <= pc_inc;
                     state    <= FETCH;
                  end
               end
            end

            HALT: begin
               mem_req     <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end

            default: begin
               state <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of the PC stream seen by the decoder.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        instr_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        halted;
   logic        fetch_err;

   int total = 0;
   int bad   = 0;

   // memory model configuration (written only by the stimulus process)
   int          lat_min = 0;
   int          lat_max = 0;
   bit          mem_mute = 1'b0;
   int          force_arm = 0;
   logic [31:0] force_data = '0;

   // memory model / protocol monitor state (written only by the memory process)
   int          force_done = 0;
   bit          busy = 1'b0;
   int          wait_cnt = 0;
   int          cur_lat = 0;
   bit          pend = 1'b0;
   logic [31:0] pend_addr = '0;
   logic        rst_q = 1'b1;
   int          mon_viol = 0;
   logic [31:0] mon_addr = '0;
   logic [31:0] mon_want = '0;

   fetch_unit #(
      .RESET_PC       (32'h0000_0100),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .dec_ready   (dec_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .halted      (halted),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   always @(posedge clk) rst_q <= rst;

   // Instruction memory with configurable latency, plus request-protocol watch.
   always @(negedge clk) begin
      if (rst_q) pend = 1'b0;
      if (pend && halted !== 1'b1) begin
         if (mem_req !== 1'b1 || mem_addr !== pend_addr) begin
            mon_viol++;
            mon_addr = mem_addr;
            mon_want = pend_addr;
         end
      end
      if (mem_req === 1'b1 && mem_addr[1:0] !== 2'b00) begin
         mon_viol++;
         mon_addr = mem_addr;
         mon_want = {mem_addr[31:2], 2'b00};
      end
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
         if (!busy) begin
            busy     = 1'b1;
            wait_cnt = 0;
            cur_lat  = $urandom_range(lat_max, lat_min);
         end
         if (!mem_mute && wait_cnt >= cur_lat) begin
            mem_ack = 1'b1;
            if (force_done < force_arm) begin
               mem_rdata = force_data;
               force_done++;
            end else begin
               mem_rdata = memfn(mem_addr);
            end
            busy = 1'b0;
         end else begin
            wait_cnt++;
         end
      end else begin
         busy = 1'b0;
      end
      pend      = (mem_req === 1'b1) && !mem_ack;
      pend_addr = mem_addr;
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; redirect_en = 1'b0; dec_ready = 1'b0; halt = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit got);
      got = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      lat_min = 0; lat_max = 0; mem_mute = 1'b0;
      @(negedge clk);
      rst = 1'b1; redirect_en = 1'b0; dec_ready = 1'b0; halt = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({mem_req, instr_valid, halted, fetch_err} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags: req/valid/halted/err=%b%b%b%b expected 0000", mem_req, instr_valid, halted, fetch_err);
      end
      total++;
      if (mem_addr !== 32'h100 || instr !== 32'h0 || instr_pc !== 32'h0) begin
         bad++;
         $display("FAIL reset_regs: addr=%h instr=%h pc=%h expected 00000100 0 0", mem_addr, instr, instr_pc);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         bad++;
         $display("FAIL reset_exit: req=%b addr=%h expected req=1 addr=00000100", mem_req, mem_addr);
      end
   endtask

   task automatic test_sequential();
      int          seen;
      int          last;
      logic [31:0] exp_pc;
      lat_min = 0; lat_max = 0;
      apply_reset();
      dec_ready = 1'b1;
      seen = 0; last = 0; exp_pc = 32'h100;
      for (int c = 0; c < 40 && seen < 3; c++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            total++;
            if (instr_pc !== exp_pc || instr !== memfn(exp_pc)) begin
               bad++;
               $display("FAIL seq_word: pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, exp_pc, memfn(exp_pc));
            end
            if (seen > 0) begin
               total++;
               if (c - last != 2) begin
                  bad++;
                  $display("FAIL seq_spacing: spacing=%0d expected 2", c - last);
               end
            end
            last = c; seen++; exp_pc = exp_pc + 32'd4;
         end
      end
      dec_ready = 1'b0;
      total++;
      if (seen != 3) begin
         bad++;
         $display("FAIL seq_count: words=%0d expected 3", seen);
      end
   endtask

   task automatic test_stall();
      bit got;
      lat_min = 0; lat_max = 0;
      apply_reset();
      wait_valid(20, got);
      total++;
      if (!got) begin
         bad++;
         $display("FAIL stall_first: no instr_valid within 20 cycles, expected a word");
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== memfn(32'h100) || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: valid=%b pc=%h instr=%h req=%b expected 1 00000100 %h 0",
                     instr_valid, instr_pc, instr, mem_req, memfn(32'h100));
         end
      end
      dec_ready = 1'b1;
      @(negedge clk);
      dec_ready = 1'b0;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h104 || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_release: req=%b addr=%h valid=%b expected 1 00000104 0", mem_req, mem_addr, instr_valid);
      end
   endtask

   task automatic test_redirect_squash();
      bit          got;
      bit          got_addr;
      logic [31:0] first_addr;
      lat_min = 0; lat_max = 0;
      apply_reset();
      wait_valid(20, got);
      lat_min = 3; lat_max = 3;
      force_data = 32'hDEAD_BEEF;
      force_arm++;
      redirect_en = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
         bad++;
         $display("FAIL squash_setup: req=%b addr=%h expected 1 00000040", mem_req, mem_addr);
      end
      redirect_pc = 32'h203;
      @(negedge clk);
      redirect_en = 1'b0;
      got = 1'b0; got_addr = 1'b0; first_addr = '0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (mem_req === 1'b1 && mem_addr !== 32'h40 && !got_addr) begin
            got_addr = 1'b1;
            first_addr = mem_addr;
         end
         if (instr_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      total++;
      if (!got_addr || first_addr !== 32'h200) begin
         bad++;
         $display("FAIL squash_next_addr: seen=%b addr=%h expected 00000200", got_addr, first_addr);
      end
      total++;
      if (!got || instr === 32'hDEAD_BEEF || instr_pc !== 32'h200 || instr !== memfn(32'h200)) begin
         bad++;
         $display("FAIL squash_word: valid=%b pc=%h instr=%h expected pc=00000200 instr=%h", got, instr_pc, instr, memfn(32'h200));
      end
      lat_min = 0; lat_max = 0;
   endtask

   task automatic test_redirect_priority();
      bit got;
      lat_min = 0; lat_max = 0;
      apply_reset();
      wait_valid(20, got);
      redirect_en = 1'b1; redirect_pc = 32'h10;
      @(negedge clk);
      redirect_en = 1'b0;
      wait_valid(20, got);
      total++;
      if (!got || instr_pc !== 32'h10) begin
         bad++;
         $display("FAIL prio_setup: valid=%b pc=%h expected 00000010", got, instr_pc);
      end
      redirect_en = 1'b1; redirect_pc = 32'h80; dec_ready = 1'b1;
      @(negedge clk);
      redirect_en = 1'b0; dec_ready = 1'b0;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h80 || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL prio_addr: req=%b addr=%h valid=%b expected 1 00000080 0", mem_req, mem_addr, instr_valid);
      end
      wait_valid(20, got);
      total++;
      if (!got || instr_pc !== 32'h80 || instr !== memfn(32'h80)) begin
         bad++;
         $display("FAIL prio_word: valid=%b pc=%h instr=%h expected pc=00000080 instr=%h", got, instr_pc, instr, memfn(32'h80));
      end
   endtask

   task automatic test_halt();
      bit got;
      lat_min = 0; lat_max = 0;
      apply_reset();
      wait_valid(20, got);
      redirect_en = 1'b1; redirect_pc = 32'h20;
      @(negedge clk);
      redirect_en = 1'b0;
      wait_valid(20, got);
      total++;
      if (!got || instr_pc !== 32'h20) begin
         bad++;
         $display("FAIL halt_setup: valid=%b pc=%h expected 00000020", got, instr_pc);
      end
      dec_ready = 1'b1; halt = 1'b1;
      @(negedge clk);
      dec_ready = 1'b0; halt = 1'b0;
      total++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL halt_enter: halted=%b valid=%b req=%b expected 1 0 0", halted, instr_valid, mem_req);
      end
      for (int i = 0; i < 20; i++) begin
         redirect_en = (i % 2 == 0);
         redirect_pc = $urandom;
         dec_ready   = $urandom_range(0, 1);
         halt        = $urandom_range(0, 1);
         @(negedge clk);
         total++;
         if (mem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_stay: req=%b halted=%b valid=%b expected 0 1 0", mem_req, halted, instr_valid);
         end
      end
      redirect_en = 1'b0; dec_ready = 1'b0; halt = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (halted !== 1'b0 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL halt_reset: halted=%b req=%b expected 0 0", halted, mem_req);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         bad++;
         $display("FAIL halt_resume: req=%b addr=%h expected 1 00000100", mem_req, mem_addr);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] tgt;
      int          delivered;
      bit          rd;
      lat_min = 0; lat_max = 3;
      apply_reset();
      exp_pc = 32'h100; delivered = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            total++;
            if (instr_pc !== exp_pc || instr !== memfn(exp_pc)) begin
               bad++;
               $display("FAIL rand_word: cycle=%0d pc=%h instr=%h expected pc=%h instr=%h",
                        c, instr_pc, instr, exp_pc, memfn(exp_pc));
            end
         end
         rd  = ($urandom_range(0, 7) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
         redirect_en = rd;
         redirect_pc = tgt;
         dec_ready   = $urandom_range(0, 1);
         if (rd) begin
            exp_pc = tgt & 32'hFFFF_FFFC;
         end else if (instr_valid === 1'b1 && dec_ready) begin
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
      end
      redirect_en = 1'b0; dec_ready = 1'b0;
      lat_min = 0; lat_max = 0;
      total++;
      if (delivered < 20) begin
         bad++;
         $display("FAIL rand_progress: delivered=%0d expected at least 20", delivered);
      end
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      int reqs;
      bit got;
      mem_mute = 1'b1;
      apply_reset();
      reqs = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (halted === 1'b1) break;
         if (mem_req === 1'b1) reqs++;
      end
      total++;
      if (reqs != 8 || fetch_err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL timeout_fault: waits=%0d err=%b halted=%b req=%b expected 8 1 1 0", reqs, fetch_err, halted, mem_req);
      end
      mem_mute = 1'b0; lat_min = 7; lat_max = 7;
      apply_reset();
      reqs = 0; got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (mem_req === 1'b1) reqs++;
      end
      total++;
      if (!got || reqs != 8 || fetch_err !== 1'b0 || halted !== 1'b0 || instr_pc !== 32'h100) begin
         bad++;
         $display("FAIL timeout_ack_wins: valid=%b reqs=%0d err=%b halted=%b pc=%h expected 1 8 0 0 00000100",
                  got, reqs, fetch_err, halted, instr_pc);
      end
      lat_min = 0; lat_max = 0;
   endtask
`else
   task automatic test_no_timeout();
      bit got;
      mem_mute = 1'b1;
      apply_reset();
      repeat (300) @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || halted !== 1'b0 || fetch_err !== 1'b0) begin
         bad++;
         $display("FAIL wait_forever: req=%b addr=%h halted=%b err=%b expected 1 00000100 0 0", mem_req, mem_addr, halted, fetch_err);
      end
      mem_mute = 1'b0;
      wait_valid(10, got);
      total++;
      if (!got || instr_pc !== 32'h100 || instr !== memfn(32'h100)) begin
         bad++;
         $display("FAIL wait_then_ack: valid=%b pc=%h instr=%h expected pc=00000100 instr=%h", got, instr_pc, instr, memfn(32'h100));
      end
   endtask
`endif

   task automatic test_protocol();
      total++;
      if (mon_viol != 0) begin
         bad++;
         $display("FAIL req_protocol: violations=%0d last addr=%h expected addr=%h", mon_viol, mon_addr, mon_want);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_squash();
      test_redirect_priority();
      test_halt();
      test_random();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_protocol();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL sim_time_limit: bench still running at 1ms, expected completion");
      $fatal(1, "time limit");
   end

endmodule
